ble_clk_switch_ctrl: RTL and testbench
======================================

// Module: ble_clk_switch_ctrl
//
// PURPOSE
//   Sequencer that produces the one-hot clk_select vector for the BLE PHY glitch-free clock mux.
//   Accepts a switch request carrying a clock index and enforces break-before-make: all selects
//   low for a guard interval, then the new select high for a settle interval, then completion.
//   Runs in the always-on system clock domain and sits between the PHY control registers and the mux.
//
// PARAMETERS
//   NUM_CLOCKS     2   number of mux inputs; also the width of clk_select
//   IDX_W          1   width of the request index; must satisfy 2**IDX_W >= NUM_CLOCKS
//   OFF_CYCLES     8   clk cycles with all selects low; >=1; must cover 3 cycles of slowest mux clock
//   SETTLE_CYCLES  8   clk cycles after the new select is driven before done; >=1
//   RESET_SEL      0   clock index selected out of reset; < NUM_CLOCKS
//
// PORTS
//   clk         in   1           controller clock
//   rst         in   1           synchronous reset, active-high
//   req_valid   in   1           switch request valid
//   req_idx     in   IDX_W       requested clock index
//   req_ready   out  1           request accepted when req_valid & req_ready
//   clk_select  out  NUM_CLOCKS  one-hot or all-zero select to the clock mux
//   cur_idx     out  IDX_W       index currently driven (or last driven)
//   busy        out  1           switch sequence in progress
//   done        out  1           1-cycle pulse: request completed
//   err         out  1           1-cycle pulse: request rejected, req_idx >= NUM_CLOCKS
//
// BEHAVIOUR
//   - All outputs are registered. Sampled rst=1 sets: state IDLE, clk_select=1<<RESET_SEL,
//     cur_idx=RESET_SEL, req_ready=1, busy=0, done=0, err=0, counter=0.
//   - Reset asserted mid-sequence aborts on the next edge to the reset values. No done or err is issued.
//   - States: IDLE, OFF, ON. req_ready=1 only in IDLE.
//   - Accept at edge T (IDLE, req_valid=1). Action depends on req_idx:
//       * req_idx >= NUM_CLOCKS: err=1 in cycle after T; state, select and index unchanged.
//       * req_idx == cur_idx: done=1 in cycle after T; no select change; busy stays 0.
//       * otherwise: latch target. After T: state OFF, clk_select=0, busy=1, req_ready=0,
//         cnt=OFF_CYCLES-1.
//   - OFF: cnt decrements each edge. At the edge where cnt==0: state ON, clk_select=1<<target,
//     cur_idx=target, cnt=SETTLE_CYCLES-1.
//   - ON: cnt decrements each edge. At the edge where cnt==0: state IDLE, busy=0, req_ready=1,
//     done=1 for one cycle.
//   - Timeline relative to accept edge T:
//       * clk_select=0 during cycles T+1..T+OFF_CYCLES.
//       * new one-hot select from T+OFF_CYCLES+1.
//       * done in cycle T+OFF_CYCLES+SETTLE_CYCLES+1.
//   - clk_select never has more than one bit set. Every change passes through all-zero for
//     exactly OFF_CYCLES cycles.
//   - req_valid while busy is ignored (requester holds it). Nothing is queued.
//   - A new request may be accepted in the same cycle done is high; done and err are never high together.
//   - Counter width is $clog2(max(OFF_CYCLES,SETTLE_CYCLES))+1; no wrap occurs.
//
// TESTING (NUM_CLOCKS=2, OFF=8, SETTLE=8, RESET_SEL=0 unless noted)
//   1. rst held 2 cycles -> clk_select=2'b01, cur_idx=0, req_ready=1, busy/done/err=0.
//   2. req idx=1 at T -> select 00 cycles T+1..T+8; 10 from T+9; done only at T+17; busy T+1..T+16.
//   3. req idx=0 while cur_idx=0 -> done at T+1; clk_select stays 01; busy never set.
//   4. NUM_CLOCKS=3, IDX_W=2, req idx=3 -> err at T+1; select unchanged; no done.
//   5. req idx=1, then req_valid held with idx=0 during busy -> ignored until done; accepted in the
//      done cycle; select returns to 01 via 8 zero cycles.
//   6. rst asserted at T+5 of a switch to 1 -> select=01, busy=0 next cycle; no done/err pulse.

Source files
------------

// File: rtl/ble_clk_switch_ctrl.sv
// ble_clk_switch_ctrl: break-before-make sequencer driving the one-hot select of the BLE PHY
// glitch-free clock mux; all selects go low for OFF_CYCLES before the new one is raised.
module ble_clk_switch_ctrl #(
    parameter int unsigned NUM_CLOCKS    = 2,
    parameter int unsigned IDX_W         = 1,
    parameter int unsigned OFF_CYCLES    = 8,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned RESET_SEL     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [IDX_W-1:0]      req_idx,
    output logic                  req_ready,
    output logic [NUM_CLOCKS-1:0] clk_select,
    output logic [IDX_W-1:0]      cur_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned MAX_CYC = (OFF_CYCLES > SETTLE_CYCLES) ? OFF_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [NUM_CLOCKS-1:0] ONE = NUM_CLOCKS'(1);
    localparam logic [IDX_W:0] NC = (IDX_W + 1)'(NUM_CLOCKS);

    typedef enum logic [1:0] {IDLE, OFF, ON} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_CLOCKS-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [IDX_W-1:0]      tgt_q, tgt_d;
    logic                  ready_q, busy_q, done_q, err_q;
    logic                  done_d, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= ONE << RESET_SEL;
            cur_q   <= IDX_W'(RESET_SEL);
            tgt_q   <= IDX_W'(RESET_SEL);
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if ({1'b0, req_idx} >= NC) begin
                        err_d = 1'b1;
                    end else if (req_idx == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = OFF;
                        sel_d   = '0;
                        tgt_d   = req_idx;
                        cnt_d   = OFF_LOAD;
                    end
                end
            end
            OFF: begin
                // cur_idx keeps the old index until the new select is actually driven
                if (cnt_q == '0) begin
                    state_d = ON;
                    sel_d   = ONE << tgt_q;
                    cur_d   = tgt_q;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ON: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = ready_q;
    assign clk_select = sel_q;
    assign cur_idx    = cur_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_ble_clk_switch_ctrl.sv
// tb_ble_clk_switch_ctrl: two configurations of the switch controller checked every cycle
// against a timeline model counted in cycles since the accepted request.
module tb_ble_clk_switch_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [0:0] idx0 = '0;
    logic [1:0] idx1 = '0;
    logic       ready0, busy0, done0, err0, ready1, busy1, done1, err1;
    logic [1:0] sel0;
    logic [0:0] cur0;
    logic [2:0] sel1;
    logic [1:0] cur1;
    int total = 0;
    int bad = 0;

    int nc[2]   = '{2, 3};
    int offc[2] = '{8, 3};
    int setc[2] = '{8, 1};
    int rsel[2] = '{0, 2};
    int m_cur[2] = '{0, 2};
    int m_rel[2] = '{0, 0};
    int m_tgt[2] = '{0, 0};
    bit m_act[2] = '{0, 0};
    bit m_done[2] = '{0, 0};
    bit m_err[2] = '{0, 0};

    always #5 clk = ~clk;

    ble_clk_switch_ctrl u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(idx0), .req_ready(ready0),
        .clk_select(sel0), .cur_idx(cur0), .busy(busy0), .done(done0), .err(err0)
    );

    ble_clk_switch_ctrl #(
        .NUM_CLOCKS(3), .IDX_W(2), .OFF_CYCLES(3), .SETTLE_CYCLES(1), .RESET_SEL(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(idx1), .req_ready(ready1),
        .clk_select(sel1), .cur_idx(cur1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_next(input int k, input bit r, input bit v, input int idx);
        if (r) begin
            m_cur[k] = rsel[k]; m_act[k] = 0; m_done[k] = 0; m_err[k] = 0;
        end else if (m_act[k]) begin
            m_err[k] = 0;
            m_rel[k]++;
            m_done[k] = (m_rel[k] == offc[k] + setc[k] + 1);
            if (m_done[k]) begin
                m_act[k] = 0;
                m_cur[k] = m_tgt[k];
            end
        end else begin
            m_done[k] = 0; m_err[k] = 0;
            if (v) begin
                if (idx >= nc[k]) m_err[k] = 1;
                else if (idx == m_cur[k]) m_done[k] = 1;
                else begin
                    m_act[k] = 1; m_rel[k] = 1; m_tgt[k] = idx;
                end
            end
        end
    endtask

    task automatic check_inst(input int k);
        bit dark = m_act[k] && m_rel[k] <= offc[k];
        int shown = (m_act[k] && !dark) ? m_tgt[k] : m_cur[k];
        logic [31:0] exp_sel = dark ? 32'd0 : (32'd1 << shown);
        check($sformatf("sel%0d", k), k == 0 ? 32'(sel0) : 32'(sel1), exp_sel);
        check($sformatf("cur%0d", k), k == 0 ? 32'(cur0) : 32'(cur1), 32'(shown));
        check($sformatf("busy%0d", k), k == 0 ? 32'(busy0) : 32'(busy1), 32'(m_act[k]));
        check($sformatf("ready%0d", k), k == 0 ? 32'(ready0) : 32'(ready1), 32'(!m_act[k]));
        check($sformatf("done%0d", k), k == 0 ? 32'(done0) : 32'(done1), 32'(m_done[k]));
        check($sformatf("err%0d", k), k == 0 ? 32'(err0) : 32'(err1), 32'(m_err[k]));
    endtask

    task automatic cyc(input bit r, input bit v, input int i0, input int i1);
        logic [31:0] a = i0;
        logic [31:0] b = i1;
        rst = r; req_valid = v; idx0 = a[0:0]; idx1 = b[1:0];
        model_next(0, r, v, i0);
        model_next(1, r, v, i1);
        @(negedge clk);
        check_inst(0);
        check_inst(1);
    endtask

    initial begin
        @(negedge clk);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 2);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 3);
        repeat (20) cyc(0, 1, 0, 0);
        repeat (20) cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 1);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
                int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
